// File: rtl/stack_sequencer_if.sv
// Bus bundle between the stack sequencer and the core / memory stage.
// master: the sequencer (drives the memory port, status and popped results).
// slave : the core side (drives requests, PC/flags to push and memory read data).
//   call_req/int_req/ret_req/rti_req  1-cycle request pulses
//   pc_in[31:0], flags_in[2:0]        values to push, sampled on accept
//   mem_rdata[15:0]                   memory read data, one cycle after mem_re
//   mem_addr, mem_wdata, mem_we, mem_re  data memory port while busy
//   busy, done, pc_out, flags_out, pc_valid, flags_valid, sp, stack_ovf, stack_unf
interface stack_sequencer_if #(
  parameter int ADDR_W = 11
);
  logic              call_req;
  logic              int_req;
  logic              ret_req;
  logic              rti_req;
  logic [31:0]       pc_in;
  logic [2:0]        flags_in;
  logic [15:0]       mem_rdata;
  logic [ADDR_W-1:0] mem_addr;
  logic [15:0]       mem_wdata;
  logic              mem_we;
  logic              mem_re;
  logic              busy;
  logic              done;
  logic [31:0]       pc_out;
  logic [2:0]        flags_out;
  logic              pc_valid;
  logic              flags_valid;
  logic [ADDR_W-1:0] sp;
  logic              stack_ovf;
  logic              stack_unf;

  modport master (
    input  call_req, int_req, ret_req, rti_req, pc_in, flags_in, mem_rdata,
    output mem_addr, mem_wdata, mem_we, mem_re, busy, done, pc_out, flags_out,
           pc_valid, flags_valid, sp, stack_ovf, stack_unf
  );

  modport slave (
    output call_req, int_req, ret_req, rti_req, pc_in, flags_in, mem_rdata,
    input  mem_addr, mem_wdata, mem_we, mem_re, busy, done, pc_out, flags_out,
           pc_valid, flags_valid, sp, stack_ovf, stack_unf
  );
endinterface

// File: rtl/stack_sequencer.sv
// Stack sequencer: moves a 32-bit PC (plus 3 flag bits for INT/RTI) to or from
// the stack as 2-3 16-bit memory words, one word per cycle, and owns the stack
// pointer. busy stalls the pipeline while the sequencer holds the memory port.
// Ports:
//   clk    system clock, rising edge
//   reset  synchronous, active-high; aborts any operation in flight
//   bus    stack_sequencer_if.master (requests, memory port, status, results)
// Optional feature: define STACK_GUARD_EN to reject pushes below STACK_LIMIT
// and pops above SP_INIT, raising the sticky stack_ovf / stack_unf flags.
module stack_sequencer #(
  parameter int ADDR_W      = 11,
  parameter int SP_INIT     = (1 << ADDR_W) - 1,
  parameter int STACK_LIMIT = (1 << ADDR_W) - 512
) (
  input logic                clk,
  input logic                reset,
  stack_sequencer_if.master  bus
);

  typedef enum logic [2:0] {
    IDLE, PUSH_HI, PUSH_LO, PUSH_FLG, POP_FLG, POP_LO, POP_HI, FIN
  } stateT;

  localparam logic [ADDR_W-1:0] SpInit = ADDR_W'(SP_INIT);

  stateT             state;
  logic [ADDR_W-1:0] sp;
  logic [ADDR_W-1:0] memAddr;
  logic [15:0]       memWdata;
  logic              memWe;
  logic              memRe;
  logic              done;
  logic [31:0]       pcOut;
  logic [2:0]        flagsOut;
  logic              pcValid;
  logic              flagsValid;
  logic              ovfFlag;
  logic              unfFlag;
  logic              isInt;
  logic              isRti;
  logic              isPop;
  logic [15:0]       pcLo;
  logic [2:0]        flagReg;
  logic [15:0]       loWord;
  logic [2:0]        flagCap;
  logic              pushRej;
  logic              popRej;

  logic [ADDR_W-1:0] spDec;
  logic [ADDR_W-1:0] spInc;
  logic [ADDR_W-1:0] spInc2;

  // Pointer arithmetic wraps modulo 2^ADDR_W.
  assign spDec  = sp - ADDR_W'(1);
  assign spInc  = sp + ADDR_W'(1);
  assign spInc2 = sp + ADDR_W'(2);

`ifdef STACK_GUARD_EN
  localparam logic [ADDR_W:0] LimitW  = (ADDR_W+1)'(STACK_LIMIT);
  localparam logic [ADDR_W:0] SpInitW = (ADDR_W+1)'(SP_INIT);

  logic [ADDR_W:0] spWide;
  logic [ADDR_W:0] pushExtra;
  logic [ADDR_W:0] popWords;

  // Compared one bit wider so the bounds do not wrap: the lowest word a push
  // touches is sp-(words-1), the highest a pop touches is sp+words.
  assign spWide    = {1'b0, sp};
  assign pushExtra = bus.int_req ? (ADDR_W+1)'(2) : (ADDR_W+1)'(1);
  assign popWords  = bus.rti_req ? (ADDR_W+1)'(3) : (ADDR_W+1)'(2);
  assign pushRej   = spWide < (LimitW + pushExtra);
  assign popRej    = (spWide + popWords) > SpInitW;
`else
  assign pushRej = 1'b0;
  assign popRej  = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      sp         <= SpInit;
      memAddr    <= '0;
      memWdata   <= '0;
      memWe      <= 1'b0;
      memRe      <= 1'b0;
      done       <= 1'b0;
      pcOut      <= '0;
      flagsOut   <= '0;
      pcValid    <= 1'b0;
      flagsValid <= 1'b0;
      ovfFlag    <= 1'b0;
      unfFlag    <= 1'b0;
      isInt      <= 1'b0;
      isRti      <= 1'b0;
      isPop      <= 1'b0;
    end else begin
      done       <= 1'b0;
      pcValid    <= 1'b0;
      flagsValid <= 1'b0;
      case (state)
        IDLE: begin
          pcLo    <= bus.pc_in[15:0];
          flagReg <= bus.flags_in;
          // Memory outputs are registered, so the first word's address and
          // data are set up here, on the accepting edge.
          if (bus.int_req || bus.call_req) begin
            if (pushRej) begin
              ovfFlag <= 1'b1;
            end else begin
              state    <= PUSH_HI;
              isInt    <= bus.int_req;
              isPop    <= 1'b0;
              memWe    <= 1'b1;
              memAddr  <= sp;
              memWdata <= bus.pc_in[31:16];
            end
          end else if (bus.rti_req || bus.ret_req) begin
            if (popRej) begin
              unfFlag <= 1'b1;
            end else begin
              state   <= bus.rti_req ? POP_FLG : POP_LO;
              isRti   <= bus.rti_req;
              isPop   <= 1'b1;
              memRe   <= 1'b1;
              memAddr <= spInc;
            end
          end
        end
        PUSH_HI: begin
          sp       <= spDec;
          memAddr  <= spDec;
          memWdata <= pcLo;
          state    <= PUSH_LO;
        end
        PUSH_LO: begin
          sp <= spDec;
          if (isInt) begin
            memAddr  <= spDec;
            memWdata <= {13'b0, flagReg};
            state    <= PUSH_FLG;
          end else begin
            memWe <= 1'b0;
            state <= FIN;
          end
        end
        PUSH_FLG: begin
          sp    <= spDec;
          memWe <= 1'b0;
          state <= FIN;
        end
        POP_FLG: begin
          sp      <= spInc;
          memAddr <= spInc2;
          state   <= POP_LO;
        end
        // Read data lags mem_re by one cycle: each state captures the word
        // requested by the state before it.
        POP_LO: begin
          sp      <= spInc;
          memAddr <= spInc2;
          flagCap <= bus.mem_rdata[2:0];
          state   <= POP_HI;
        end
        POP_HI: begin
          sp     <= spInc;
          memRe  <= 1'b0;
          loWord <= bus.mem_rdata;
          state  <= FIN;
        end
        FIN: begin
          state <= IDLE;
          done  <= 1'b1;
          if (isPop) begin
            pcOut   <= {bus.mem_rdata, loWord};
            pcValid <= 1'b1;
            if (isRti) begin
              flagsOut   <= flagCap;
              flagsValid <= 1'b1;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.mem_addr    = memAddr;
  assign bus.mem_wdata   = memWdata;
  assign bus.mem_we      = memWe;
  assign bus.mem_re      = memRe;
  assign bus.busy        = (state != IDLE);
  assign bus.done        = done;
  assign bus.pc_out      = pcOut;
  assign bus.flags_out   = flagsOut;
  assign bus.pc_valid    = pcValid;
  assign bus.flags_valid = flagsValid;
  assign bus.sp          = sp;
`ifdef STACK_GUARD_EN
  assign bus.stack_ovf   = ovfFlag;
  assign bus.stack_unf   = unfFlag;
`else
  assign bus.stack_ovf   = 1'b0;
  assign bus.stack_unf   = 1'b0;
`endif

endmodule

// File: tb/tb_stack_sequencer.sv
module tb_stack_sequencer;

  localparam int ADDR_W = 11;

  logic clk = 1'b0;
  logic reset;

  stack_sequencer_if #(.ADDR_W(ADDR_W)) bus ();

  stack_sequencer #(.ADDR_W(ADDR_W)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [ADDR_W-1:0] addr;
    logic [15:0]       data;
  } wrT;

  typedef struct {
    logic [31:0] pc;
    logic [2:0]  fl;
  } frameT;

  typedef struct {
    logic [31:0] pc;
    bit          hasFl;
    logic [2:0]  fl;
  } resT;

  wrT                wrQ[$];
  logic [ADDR_W-1:0] rdQ[$];
  resT               resQ[$];
  frameT             stk[$];
  logic [ADDR_W-1:0] spM;

  int testsRun = 0;
  int testsFailed = 0;

  logic [15:0] mem [0:(1<<ADDR_W)-1];

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    testsRun++;
    if (got !== exp) begin
      testsFailed++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Synchronous memory: read data appears the cycle after mem_re.
  always @(posedge clk) begin
    if (bus.mem_we) mem[bus.mem_addr] <= bus.mem_wdata;
    if (bus.mem_re) bus.mem_rdata <= mem[bus.mem_addr];
  end

  // Scoreboard monitor.
  always @(negedge clk) begin
    wrT                e;
    logic [ADDR_W-1:0] a;
    resT               r;
    if (bus.mem_we || bus.mem_re) chk("we_re_exclusive", bus.mem_we & bus.mem_re, 0);
    if (bus.mem_we) begin
      if (wrQ.size() == 0) chk("unexpected_write", bus.mem_we, 0);
      else begin
        e = wrQ.pop_front();
        chk("wr_addr", bus.mem_addr, e.addr);
        chk("wr_data", bus.mem_wdata, e.data);
      end
    end
    if (bus.mem_re) begin
      if (rdQ.size() == 0) chk("unexpected_read", bus.mem_re, 0);
      else begin
        a = rdQ.pop_front();
        chk("rd_addr", bus.mem_addr, a);
      end
    end
    if (bus.pc_valid) begin
      if (resQ.size() == 0) chk("unexpected_pop", bus.pc_valid, 0);
      else begin
        r = resQ.pop_front();
        chk("pc_out", bus.pc_out, r.pc);
        if (r.hasFl) chk("flags_out", bus.flags_out, r.fl);
      end
    end
  end

  // req = {int, call, rti, ret}
  task automatic doOp(input logic [3:0] req, input logic [31:0] pc,
                      input logic [2:0] fl, input bit dropCall);
    int    kind;
    int    lat;
    int    n;
    frameT f;
    kind = req[3] ? 1 : req[2] ? 0 : req[1] ? 3 : 2;
    lat  = (kind == 1 || kind == 3) ? 5 : 4;
    case (kind)
      0: begin
        wrQ.push_back('{spM, pc[31:16]});
        wrQ.push_back('{spM - 11'd1, pc[15:0]});
        spM = spM - 11'd2;
        stk.push_back('{pc, fl});
      end
      1: begin
        wrQ.push_back('{spM, pc[31:16]});
        wrQ.push_back('{spM - 11'd1, pc[15:0]});
        wrQ.push_back('{spM - 11'd2, {13'b0, fl}});
        spM = spM - 11'd3;
        stk.push_back('{pc, fl});
      end
      2: begin
        f = stk.pop_back();
        rdQ.push_back(spM + 11'd1);
        rdQ.push_back(spM + 11'd2);
        resQ.push_back('{f.pc, 1'b0, 3'b0});
        spM = spM + 11'd2;
      end
      default: begin
        f = stk.pop_back();
        rdQ.push_back(spM + 11'd1);
        rdQ.push_back(spM + 11'd2);
        rdQ.push_back(spM + 11'd3);
        resQ.push_back('{f.pc, 1'b1, f.fl});
        spM = spM + 11'd3;
      end
    endcase
    {bus.int_req, bus.call_req, bus.rti_req, bus.ret_req} = req;
    bus.pc_in    = pc;
    bus.flags_in = fl;
    n = 0;
    do begin
      @(negedge clk);
      n++;
      if (n == 1) begin
        {bus.int_req, bus.call_req, bus.rti_req, bus.ret_req} = 4'b0;
        chk("busy", bus.busy, 1);
      end
      if (dropCall && n == 2) bus.call_req = 1'b1;
      if (dropCall && n == 3) bus.call_req = 1'b0;
    end while (!bus.done && n < 20);
    chk("latency", n, lat);
    chk("pc_valid", bus.pc_valid, (kind >= 2));
    chk("flags_valid", bus.flags_valid, (kind == 3));
    chk("sp", bus.sp, spM);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] pcs [3];
    bus.call_req = 0; bus.int_req = 0; bus.ret_req = 0; bus.rti_req = 0;
    bus.pc_in = '0; bus.flags_in = '0;
    reset = 1'b1;
    spM = 11'h7FF;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    chk("rst_busy", bus.busy, 0);
    chk("rst_sp", bus.sp, 11'h7FF);
    chk("rst_done", bus.done, 0);
    chk("rst_we", bus.mem_we, 0);
    chk("rst_re", bus.mem_re, 0);
    chk("rst_pc_out", bus.pc_out, 0);
    chk("rst_ovf", bus.stack_ovf, 0);
    chk("rst_unf", bus.stack_unf, 0);

    // CALL then RET
    doOp(4'b0100, 32'h0001_2345, 3'b0, 1'b0);
    chk("call_sp", bus.sp, 11'h7FD);
    doOp(4'b0001, 32'h0, 3'b0, 1'b0);
    chk("ret_sp", bus.sp, 11'h7FF);

    // INT then RTI
    doOp(4'b1000, 32'h0000_000A, 3'b101, 1'b0);
    doOp(4'b0010, 32'h0, 3'b0, 1'b0);
    chk("rti_flags", bus.flags_out, 3'b101);

    // INT and CALL together, CALL while busy is dropped
    doOp(4'b1100, 32'hDEAD_BEEF, 3'b011, 1'b1);
    chk("drop_wr_drained", wrQ.size(), 0);
    // RTI and RET together: RTI wins
    doOp(4'b0011, 32'h0, 3'b0, 1'b0);

    // Nested calls, back-to-back, popped in LIFO order
    for (int i = 0; i < 3; i++) begin
      pcs[i] = $urandom;
      doOp(4'b0100, pcs[i], 3'b0, 1'b0);
    end
    for (int i = 0; i < 3; i++) doOp(4'b0001, 32'h0, 3'b0, 1'b0);
    chk("pc_hold", bus.pc_out, pcs[0]);
    @(negedge clk);
    chk("pc_hold_idle", bus.pc_out, pcs[0]);
    chk("pc_valid_pulse", bus.pc_valid, 0);

    // Reset during PUSH_LO
    wrQ.push_back('{spM, 16'h1234});
    wrQ.push_back('{spM - 11'd1, 16'h5678});
    bus.call_req = 1'b1; bus.pc_in = 32'h1234_5678;
    @(negedge clk);
    bus.call_req = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    spM = 11'h7FF;
    stk.delete();
    chk("abort_busy", bus.busy, 0);
    chk("abort_sp", bus.sp, 11'h7FF);
    chk("abort_done", bus.done, 0);
    chk("abort_we", bus.mem_we, 0);
    @(negedge clk);
    chk("abort_no_done", bus.done, 0);

`ifdef STACK_GUARD_EN
    bus.ret_req = 1'b1;
    @(negedge clk);
    bus.ret_req = 1'b0;
    for (int i = 0; i < 3; i++) begin
      chk("unf_busy", bus.busy, 0);
      chk("unf_done", bus.done, 0);
      @(negedge clk);
    end
    chk("stack_unf", bus.stack_unf, 1);
    chk("unf_sp", bus.sp, 11'h7FF);
    doOp(4'b1000, 32'h55, 3'b001, 1'b0);
    for (int i = 0; i < 254; i++) doOp(4'b0100, 32'(i), 3'b0, 1'b0);
    chk("limit_sp", bus.sp, 11'h600);
    bus.call_req = 1'b1;
    @(negedge clk);
    bus.call_req = 1'b0;
    for (int i = 0; i < 3; i++) begin
      chk("ovf_busy", bus.busy, 0);
      chk("ovf_done", bus.done, 0);
      @(negedge clk);
    end
    chk("stack_ovf", bus.stack_ovf, 1);
    chk("ovf_sp", bus.sp, 11'h600);
`else
    chk("no_guard_ovf", bus.stack_ovf, 0);
    chk("no_guard_unf", bus.stack_unf, 0);
`endif

    repeat (2) @(negedge clk);
    chk("wrq_drained", wrQ.size(), 0);
    chk("rdq_drained", rdQ.size(), 0);
    chk("resq_drained", resQ.size(), 0);
    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
